// File: rtl/error_report_tx.sv
// error_report_tx: renders each accepted tap-count word as uppercase hex ASCII + CR LF on a UART 8N1 line.
// Define ERROR_REPORT_SEPARATOR_EN to insert a space between tap groups.
module error_report_tx #(
   parameter int COUNT_WIDTH  = 8,
   parameter int DELAY_TAPS   = 4,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                I_STB,
   input  logic [DELAY_TAPS*COUNT_WIDTH-1:0]   I_DAT,
   output logic                                I_RDY,
   output logic                                O_TX,
   output logic                                O_BUSY,
   output logic [7:0]                          O_DROP
);
   localparam int W    = DELAY_TAPS*COUNT_WIDTH;
   localparam int NCH  = W/4;
`ifdef ERROR_REPORT_SEPARATOR_EN
   localparam int G    = COUNT_WIDTH/4;
   localparam int NSEP = DELAY_TAPS-1;
`else
   localparam int NSEP = 0;
`endif
   localparam int NTXT = NCH+NSEP;
   localparam int NTOT = NTXT+2;
   localparam int IW   = $clog2(NTOT);
   localparam int CW   = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    word_q, word_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [2:0]      bit_q, bit_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      drop_q, drop_d;
   logic            tx_q, tx_d;
   logic [7:0]      ch_d;
   logic            last;

   // Character at frame position i: hex nibbles (MSB first), optional spaces, then CR LF
   function automatic logic [7:0] char_at(input logic [W-1:0] w, input logic [IW-1:0] i);
      int ii, k;
      logic [3:0] n;
      ii = int'(i);
`ifdef ERROR_REPORT_SEPARATOR_EN
      k = (ii/(G+1))*G + ii%(G+1);
      if (ii < NTXT && ii%(G+1) == G) return 8'h20;
`else
      k = ii;
`endif
      if (ii == NTXT) return 8'h0D;
      if (ii > NTXT) return 8'h0A;
      n = 4'(w >> (4*(NCH-1-k)));
      return n < 4'd10 ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
   endfunction

   assign last = cnt_q == CW'(CLKS_PER_BIT-1);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         drop_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      bit_d   = bit_q;
      cnt_d   = (last || state_q == IDLE) ? '0 : cnt_q + CW'(1);
      drop_d  = (I_STB && state_q != IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      case (state_q)
         IDLE:
            if (I_STB) begin
               state_d = START;
               word_d  = I_DAT;
               idx_d   = '0;
            end
         START:
            if (last) begin
               state_d = DATA;
               bit_d   = '0;
            end
         DATA:
            if (last) begin
               bit_d   = bit_q + 3'd1;
               state_d = bit_q == 3'd7 ? STOP : DATA;
            end
         STOP:
            if (last) begin
               state_d = idx_q == IW'(NTOT-1) ? IDLE : START;
               idx_d   = idx_q == IW'(NTOT-1) ? idx_q : idx_q + IW'(1);
            end
         default: state_d = IDLE;
      endcase
   end

   // Line level is derived from the next state so the start bit appears the cycle after acceptance
   always_comb begin
      ch_d = char_at(word_d, idx_d);
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? ch_d[bit_d] : 1'b1;
   end

   assign I_RDY  = state_q == IDLE;
   assign O_BUSY = state_q != IDLE;
   assign O_TX   = tx_q;
   assign O_DROP = drop_q;
endmodule

// File: tb/tb_error_report_tx.sv
// tb_error_report_tx: table-driven frame checks plus drop, back-to-back and mid-frame reset sequences.
module tb_error_report_tx;
   localparam int CPB = 4;
`ifdef ERROR_REPORT_SEPARATOR_EN
   localparam int NT = 13;
`else
   localparam int NT = 10;
`endif
   localparam logic [15:0] CRLF = 16'h0D0A;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        I_STB = 1'b0;
   logic [31:0] I_DAT = '0;
   logic        I_RDY, O_TX, O_BUSY;
   logic [7:0]  O_DROP;

   int n_chk = 0;
   int n_fail = 0;
   int exp_drop = 0;

   typedef struct {
      logic [31:0]     w;
      logic [8*NT-1:0] txt;
   } vec_t;
   vec_t vecs[4];

   error_report_tx #(.COUNT_WIDTH(8), .DELAY_TAPS(4), .CLKS_PER_BIT(CPB)) dut (
      .CLK(CLK), .RST(RST), .I_STB(I_STB), .I_DAT(I_DAT),
      .I_RDY(I_RDY), .O_TX(O_TX), .O_BUSY(O_BUSY), .O_DROP(O_DROP)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; strobes w, then checks every line sample of the frame
   task automatic frame(input logic [31:0] w, input logic [8*NT-1:0] txt, input int ndrop);
      logic [10*CPB-1:0] got, exp;
      logic [7:0] ch;
      logic rdy_last;
      int b, t;
      rdy_last = 1'b1;
      chk("rdy_before_strobe", 64'(I_RDY), 64'd1);
      I_STB = 1'b1;
      I_DAT = w;
      @(negedge CLK);
      I_STB = 1'b0;
      I_DAT = ~w;
      for (int c = 0; c < NT; c++) begin
         ch = txt[8*(NT-c)-1 -: 8];
         for (int j = 0; j < 10*CPB; j++) begin
            b = j/CPB;
            exp[j] = b == 0 ? 1'b0 : b == 9 ? 1'b1 : ch[b-1];
            got[j] = O_TX;
            rdy_last = I_RDY;
            t = c*10*CPB + j;
            I_STB = t >= 1 && t < 1+ndrop;
            if (I_STB) exp_drop = exp_drop == 255 ? 255 : exp_drop + 1;
            @(negedge CLK);
         end
         chk($sformatf("char%0d_line", c), 64'(got), 64'(exp));
      end
      I_STB = 1'b0;
      chk("frame_len_rdy", 64'({rdy_last, I_RDY}), 64'(2'b01));
      chk("drop_count", 64'(O_DROP), 64'(exp_drop));
   endtask

   initial begin
`ifdef ERROR_REPORT_SEPARATOR_EN
      vecs[0] = '{32'h01A2FF00, {"01 A2 FF 00", CRLF}};
      vecs[1] = '{32'hDEADBEEF, {"DE AD BE EF", CRLF}};
      vecs[2] = '{32'h9A5C3B70, {"9A 5C 3B 70", CRLF}};
      vecs[3] = '{32'h0F1E2D3C, {"0F 1E 2D 3C", CRLF}};
`else
      vecs[0] = '{32'h01A2FF00, {"01A2FF00", CRLF}};
      vecs[1] = '{32'hDEADBEEF, {"DEADBEEF", CRLF}};
      vecs[2] = '{32'h9A5C3B70, {"9A5C3B70", CRLF}};
      vecs[3] = '{32'h0F1E2D3C, {"0F1E2D3C", CRLF}};
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("reset_state", 64'({O_TX, I_RDY, O_BUSY, O_DROP}), 64'({1'b1, 1'b1, 1'b0, 8'd0}));
      end
      RST = 1'b1;
      @(negedge CLK);
      // Frames follow each other on the first ready cycle
      for (int i = 0; i < 4; i++) frame(vecs[i].w, vecs[i].txt, 0);
      frame(vecs[0].w, vecs[0].txt, 3);
      frame(vecs[2].w, vecs[2].txt, 300);
      I_STB = 1'b1;
      I_DAT = vecs[1].w;
      @(negedge CLK);
      I_STB = 1'b0;
      repeat (130) @(negedge CLK);
      chk("tx_low_mid_char3", 64'(O_TX), 64'd0);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      exp_drop = 0;
      chk("mid_frame_reset", 64'({O_TX, I_RDY, O_BUSY, O_DROP}), 64'({1'b1, 1'b1, 1'b0, 8'd0}));
      frame(vecs[3].w, vecs[3].txt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
